// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared types and constants for the write-back buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int WORD_OFFSET      = 2;
    localparam int ENTRY_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic                                  valid;
        logic [ENTRY_DATA_WIDTH-1:WORD_OFFSET] addr;
        logic [ENTRY_DATA_WIDTH-1:0]           data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/writeback_buffer_if.sv
// ============================================================================
// Module : writeback_buffer_if
// Brief  : Cache-side push, miss lookup and memory write bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface writeback_buffer_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  wb_enable;
    logic [DATA_WIDTH-1:0] wb_address;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_full;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] rd_address;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;

    modport master (
        output wb_enable, wb_address, wb_data, rd_address, mem_ack,
        input  wb_full, overflow, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  wb_enable, wb_address, wb_data, rd_address, mem_ack,
        output wb_full, overflow, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata
    );

endinterface

`default_nettype wire

// File: rtl/wb_match_unit.sv
// ============================================================================
// Module : wb_match_unit
// Brief  : Combinational newest-first address matcher over buffer entries.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_match_unit
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                             i_valid,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:WORD_OFFSET]   i_addr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]             i_data,
    input  logic [PTR_WIDTH-1:0]                         i_tail,
    input  logic [DATA_WIDTH-1:WORD_OFFSET]              i_lookup,
    output logic                                         o_hit,
    output logic [PTR_WIDTH-1:0]                         o_idx,
    output logic [DATA_WIDTH-1:0]                        o_data
);

    logic [PTR_WIDTH-1:0] w_pos;

    // Walk from oldest (k = DEPTH-1) to newest (k = 0); the last match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        o_data = '0;
        w_pos  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_pos = i_tail - PTR_WIDTH'(k + 1);
            if (i_valid[w_pos] && (i_addr[w_pos] == i_lookup)) begin
                o_hit  = 1'b1;
                o_idx  = w_pos;
                o_data = i_data[w_pos];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback_buffer.sv
// ============================================================================
// Module : writeback_buffer
// Brief  : Coalescing write-back FIFO with miss-fill forwarding and drain FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module writeback_buffer
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    writeback_buffer_if.slave  bus
);

    localparam logic [PTR_WIDTH:0] c_FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] c_ONE_COUNT  = (PTR_WIDTH + 1)'(1);

    wb_state_t                                r_state;
    wb_state_t                                w_state_next;
    logic [PTR_WIDTH:0]                       r_count;
    logic [PTR_WIDTH-1:0]                     r_head;
    logic [PTR_WIDTH-1:0]                     r_tail;
    logic [DEPTH-1:0]                         r_valid;
    logic [DEPTH-1:0][DATA_WIDTH-1:WORD_OFFSET] r_addr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]         r_data;
    logic                                     r_overflow;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_coal;
    logic                  w_alloc;
    logic [DEPTH-1:0]      w_coal_valid;
    logic                  w_coal_hit;
    logic [PTR_WIDTH-1:0]  w_coal_idx;
    logic [DATA_WIDTH-1:0] w_coal_data;
    logic                  w_fwd_hit;
    logic [PTR_WIDTH-1:0]  w_fwd_idx;
    logic [DATA_WIDTH-1:0] w_fwd_data;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_unused;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_push  = bus.wb_enable & ~w_full;
    assign w_pop   = (r_state == WRITE) & bus.mem_ack;
    assign w_coal  = w_push & w_coal_hit;
    assign w_alloc = w_push & ~w_coal_hit;

    // The head being drained must never absorb a coalescing write.
    always_comb begin
        w_coal_valid = r_valid;
        if (r_state == WRITE) begin
            w_coal_valid[r_head] = 1'b0;
        end
    end

    wb_match_unit #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_coal_match (
        .i_valid  (w_coal_valid),
        .i_addr   (r_addr),
        .i_data   (r_data),
        .i_tail   (r_tail),
        .i_lookup (bus.wb_address[DATA_WIDTH-1:WORD_OFFSET]),
        .o_hit    (w_coal_hit),
        .o_idx    (w_coal_idx),
        .o_data   (w_coal_data)
    );

    wb_match_unit #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_fwd_match (
        .i_valid  (r_valid),
        .i_addr   (r_addr),
        .i_data   (r_data),
        .i_tail   (r_tail),
        .i_lookup (bus.rd_address[DATA_WIDTH-1:WORD_OFFSET]),
        .o_hit    (w_fwd_hit),
        .o_idx    (w_fwd_idx),
        .o_data   (w_fwd_data)
    );

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = {r_addr[r_head], {WORD_OFFSET{1'b0}}};
                w_mem_wdata = r_data[r_head];
                if (w_pop && (r_count == c_ONE_COUNT)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_valid    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.wb_enable && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_WIDTH'(1);
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_WIDTH'(1);
            end
            r_count <= r_count + (PTR_WIDTH + 1)'(w_alloc) - (PTR_WIDTH + 1)'(w_pop);
        end
    end

    // Payload needs no reset: every read of it is qualified by a valid bit.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= bus.wb_address[DATA_WIDTH-1:WORD_OFFSET];
            r_data[r_tail] <= bus.wb_data;
        end else if (w_coal) begin
            r_data[w_coal_idx] <= bus.wb_data;
        end
    end

    assign bus.wb_full   = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.fwd_hit   = w_fwd_hit;
    assign bus.fwd_data  = w_fwd_data;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign w_unused = ^{bus.wb_address[WORD_OFFSET-1:0], bus.rd_address[WORD_OFFSET-1:0],
                        w_coal_data, w_fwd_idx};

endmodule

`default_nettype wire

// File: tb/tb_writeback_buffer.sv
// ============================================================================
// Module : tb_writeback_buffer
// Brief  : Directed and randomized checks of writeback_buffer against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_buffer;
    import wb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_buffer_if #(.DATA_WIDTH(32)) bus ();

    writeback_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: pending entries oldest-first; m_locked means q[0] is being written.
    wb_entry_t   q[$];
    bit          m_locked;
    bit          m_overflow;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input logic [29:0] a, input bit skip_head);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!(skip_head && i == 0) && q[i].addr == a) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int n;
        int idx;
        bit pop;
        if (!rst_n) begin
            q.delete();
            m_locked   = 1'b0;
            m_overflow = 1'b0;
            return;
        end
        n   = q.size();
        pop = m_locked && bus.mem_ack;
        if (bus.wb_enable) begin
            if (n == 4) begin
                m_overflow = 1'b1;
            end else begin
                idx = m_find(bus.wb_address[31:2], m_locked);
                if (idx >= 0) q[idx].data = bus.wb_data;
                else q.push_back('{valid: 1'b1, addr: bus.wb_address[31:2], data: bus.wb_data});
            end
        end
        if (pop) void'(q.pop_front());
        if (m_locked) m_locked = !(pop && n == 1);
        else          m_locked = (n > 0);
    endtask

    task automatic check_model();
        int          idx;
        logic [31:0] exp_data;
        check("m_wb_full",  32'(bus.wb_full),  32'(q.size() == 4));
        check("m_overflow", 32'(bus.overflow), 32'(m_overflow));
        check("m_mem_we",   32'(bus.mem_we),   32'(m_locked));
        if (m_locked) begin
            check("m_mem_addr",  bus.mem_addr,  {q[0].addr, 2'b00});
            check("m_mem_wdata", bus.mem_wdata, q[0].data);
        end
        idx      = m_find(bus.rd_address[31:2], 1'b0);
        exp_data = (idx >= 0) ? q[idx].data : 32'h0;
        check("m_fwd_hit",  32'(bus.fwd_hit), 32'(idx >= 0));
        check("m_fwd_data", bus.fwd_data, exp_data);
    endtask

    task automatic step();
        if (rst_n && bus.mem_we === 1'b1 && bus.mem_ack === 1'b1) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        bus.wb_enable  = 1'b1;
        bus.wb_address = a;
        bus.wb_data    = d;
        step();
        bus.wb_enable  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.wb_enable = 1'b0;
        bus.mem_ack   = 1'b0;
        step();
        rst_n = 1'b1;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic drain(input int cycles);
        bus.wb_enable = 1'b0;
        bus.mem_ack   = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        bus.mem_ack = 1'b0;
    endtask

    function automatic logic [31:0] log_a(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_d(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bus.wb_enable  = 1'b0;
        bus.wb_address = '0;
        bus.wb_data    = '0;
        bus.rd_address = '0;
        bus.mem_ack    = 1'b0;

        // Reset values and single-entry latency
        do_reset();
        check("rst_mem_we",    32'(bus.mem_we),  32'h0);
        check("rst_wb_full",   32'(bus.wb_full), 32'h0);
        check("rst_fwd_hit",   32'(bus.fwd_hit), 32'h0);
        check("rst_fwd_data",  bus.fwd_data,     32'h0);
        check("rst_mem_addr",  bus.mem_addr,     32'h0);
        check("rst_mem_wdata", bus.mem_wdata,    32'h0);
        bus.rd_address = 32'h100;
        push(32'h100, 32'hAA);
        check("t1_we_at_n", 32'(bus.mem_we), 32'h0);
        step();
        check("t1_we_n1",    32'(bus.mem_we), 32'h1);
        check("t1_addr",     bus.mem_addr,    32'h100);
        check("t1_wdata",    bus.mem_wdata,   32'hAA);
        check("t1_fwd_lock", bus.fwd_data,    32'hAA);
        bus.mem_ack = 1'b1;
        step();
        check("t1_we_done",  32'(bus.mem_we),  32'h0);
        check("t1_fwd_gone", 32'(bus.fwd_hit), 32'h0);
        step();
        check("t1_ack_idle", 32'(bus.mem_we), 32'h0);
        bus.mem_ack = 1'b0;

        // Fill, overflow, then back-to-back drain in order
        do_reset();
        for (int i = 1; i <= 4; i++) push(32'(i * 16), 32'(i * 17));
        check("t2_full", 32'(bus.wb_full), 32'h1);
        bus.rd_address = 32'h50;
        push(32'h50, 32'h55);
        check("t2_overflow", 32'(bus.overflow), 32'h1);
        check("t2_dropped",  32'(bus.fwd_hit),  32'h0);
        drain(4);
        check("t2_nwrites", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_order", log_a(i), 32'((i + 1) * 16));
        check("t2_empty", 32'(bus.mem_we), 32'h0);

        // Coalescing into a non-head entry
        do_reset();
        push(32'h200, 32'h1);
        push(32'h204, 32'h2);
        push(32'h207, 32'h3);
        bus.rd_address = 32'h204;
        step();
        check("t3_fwd_hit",  32'(bus.fwd_hit), 32'h1);
        check("t3_fwd_data", bus.fwd_data,     32'h3);
        drain(6);
        check("t3_nwrites", 32'(log_addr.size()), 32'd2);
        check("t3_a0", log_a(0), 32'h200);
        check("t3_d0", log_d(0), 32'h1);
        check("t3_a1", log_a(1), 32'h204);
        check("t3_d1", log_d(1), 32'h3);

        // Same address as locked head allocates; newest forwards
        do_reset();
        push(32'h300, 32'h5);
        step();
        push(32'h300, 32'h6);
        bus.rd_address = 32'h300;
        step();
        check("t4_hit",  32'(bus.fwd_hit), 32'h1);
        check("t4_data", bus.fwd_data,     32'h6);
        bus.rd_address = 32'h304;
        step();
        check("t4_miss_hit",  32'(bus.fwd_hit), 32'h0);
        check("t4_miss_data", bus.fwd_data,     32'h0);
        drain(6);
        check("t4_nwrites", 32'(log_addr.size()), 32'd2);
        check("t4_d0", log_d(0), 32'h5);
        check("t4_d1", log_d(1), 32'h6);

        // Push and ack together on a full buffer
        do_reset();
        for (int i = 1; i <= 4; i++) push(32'(i * 16), 32'(i));
        check("t5_pre_ovf", 32'(bus.overflow), 32'h0);
        bus.mem_ack    = 1'b1;
        bus.rd_address = 32'h50;
        push(32'h50, 32'h55);
        bus.mem_ack = 1'b0;
        check("t5_overflow", 32'(bus.overflow), 32'h1);
        check("t5_not_full", 32'(bus.wb_full),  32'h0);
        check("t5_dropped",  32'(bus.fwd_hit),  32'h0);
        drain(6);
        check("t5_nwrites", 32'(log_addr.size()), 32'd4);

        // Reset while writing, with overflow still set
        push(32'h400, 32'h9);
        step();
        check("t6_we", 32'(bus.mem_we), 32'h1);
        bus.rd_address = 32'h400;
        log_addr.delete();
        log_data.delete();
        rst_n       = 1'b0;
        bus.mem_ack = 1'b0;
        step();
        check("t6_we_rst",  32'(bus.mem_we),   32'h0);
        check("t6_ovf_rst", 32'(bus.overflow), 32'h0);
        check("t6_full",    32'(bus.wb_full),  32'h0);
        check("t6_fwd",     32'(bus.fwd_hit),  32'h0);
        rst_n = 1'b1;
        drain(4);
        check("t6_nwrites", 32'(log_addr.size()), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            rst_n          = ($urandom_range(0, 79) != 0);
            bus.wb_enable  = $urandom_range(0, 1) == 1;
            bus.wb_address = 32'h800 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            bus.wb_data    = $urandom;
            bus.rd_address = 32'h800 + 32'($urandom_range(0, 6) * 4);
            bus.mem_ack    = $urandom_range(0, 2) != 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
